// File: rtl/gt_comparator.sv
// Registered magnitude comparator (>, ==, <) with a saturating count of
// sampled greater-than results. Signed mode biases the sign bit before comparing.
module gt_comparator #(
    parameter int WIDTH  = 2,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cnt_clr,
    output logic             out_valid,
    output logic             agtb,
    output logic             aeqb,
    output logic             altb,
    output logic [CNT_W-1:0] gt_count
);

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_res_t;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] SIGN_FLIP =
        (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;
    cmp_res_t         res;

    always_comb begin
        a_key  = a ^ SIGN_FLIP;
        b_key  = b ^ SIGN_FLIP;
        res    = '0;
        res.gt = (a_key > b_key);
        res.eq = (a_key == b_key);
        res.lt = (a_key < b_key);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            agtb      <= 1'b0;
            aeqb      <= 1'b0;
            altb      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                agtb <= res.gt;
                aeqb <= res.eq;
                altb <= res.lt;
            end
        end
    end

    // Clear beats a coincident increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_count <= '0;
        end else if (cnt_clr) begin
            gt_count <= '0;
        end else if (in_valid && res.gt && (gt_count != CNT_MAX)) begin
            gt_count <= gt_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_gt_comparator.sv
// Directed bench for gt_comparator: default unsigned, CNT_W=2 saturation and
// signed instances driven from shared stimulus.
module tb_gt_comparator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] a;
    logic [1:0] b;
    logic       cnt_clr;

    logic       m_ov, m_gt, m_eq, m_lt;
    logic [7:0] m_cnt;
    logic       s_ov, s_gt, s_eq, s_lt;
    logic [1:0] s_cnt;
    logic       g_ov, g_gt, g_eq, g_lt;
    logic [7:0] g_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gt_comparator #(.WIDTH(2), .SIGNED(0), .CNT_W(8)) u_main (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .cnt_clr(cnt_clr), .out_valid(m_ov), .agtb(m_gt), .aeqb(m_eq),
        .altb(m_lt), .gt_count(m_cnt)
    );

    gt_comparator #(.WIDTH(2), .SIGNED(0), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .cnt_clr(cnt_clr), .out_valid(s_ov), .agtb(s_gt), .aeqb(s_eq),
        .altb(s_lt), .gt_count(s_cnt)
    );

    gt_comparator #(.WIDTH(2), .SIGNED(1), .CNT_W(8)) u_sgn (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
        .cnt_clr(cnt_clr), .out_valid(g_ov), .agtb(g_gt), .aeqb(g_eq),
        .altb(g_lt), .gt_count(g_cnt)
    );

    // Drive inputs, then sample 1 time unit after the next rising edge.
    task automatic apply(input logic [1:0] ta, input logic [1:0] tb_v,
                         input logic v, input logic c);
        a = ta; b = tb_v; in_valid = v; cnt_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0; a = 2'b00; b = 2'b00;
        #3;
        checks++;
        if ({m_ov, m_gt, m_eq, m_lt, m_cnt} !== 12'h000) begin
            errors++; $display("FAIL reset_main got %h exp 000", {m_ov, m_gt, m_eq, m_lt, m_cnt});
        end
        @(posedge clk); #1;
        checks++;
        if ({s_ov, s_gt, s_eq, s_lt, s_cnt, g_ov, g_gt, g_eq, g_lt} !== 10'h0) begin
            errors++; $display("FAIL reset_others got %h exp 000",
                               {s_ov, s_gt, s_eq, s_lt, s_cnt, g_ov, g_gt, g_eq, g_lt});
        end
        rst_n = 1'b1;
        apply(2'b11, 2'b00, 1'b0, 1'b0);
        checks++;
        if ({m_ov, m_gt, m_eq, m_lt, m_cnt} !== 12'h000) begin
            errors++; $display("FAIL reset_idle got %h exp 000", {m_ov, m_gt, m_eq, m_lt, m_cnt});
        end
    endtask

    task automatic test_sweep;
        logic [15:0] gt_tab;
        logic [3:0]  exp_v;
        gt_tab = 16'h7310; // bits a*4+b: (1,0)(2,0)(2,1)(3,0)(3,1)(3,2)
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                apply(2'(i), 2'(j), 1'b1, 1'b0);
                exp_v = {1'b1, gt_tab[i*4+j], (i == j), (!gt_tab[i*4+j] && i != j)};
                checks++;
                if ({m_ov, m_gt, m_eq, m_lt} !== exp_v) begin
                    errors++; $display("FAIL sweep a=%0d b=%0d got %b exp %b",
                                       i, j, {m_ov, m_gt, m_eq, m_lt}, exp_v);
                end
            end
        end
        checks++;
        if (m_cnt !== 8'd6) begin
            errors++; $display("FAIL sweep_count got %0d exp 6", m_cnt);
        end
    endtask

    task automatic test_hold;
        apply(2'b10, 2'b01, 1'b1, 1'b0);
        checks++;
        if ({m_ov, m_gt, m_eq, m_lt, m_cnt} !== {4'b1100, 8'd7}) begin
            errors++; $display("FAIL hold_sample got %h exp c07", {m_ov, m_gt, m_eq, m_lt, m_cnt});
        end
        apply(2'b00, 2'b11, 1'b0, 1'b0);
        checks++;
        if ({m_ov, m_gt, m_eq, m_lt, m_cnt} !== {4'b0100, 8'd7}) begin
            errors++; $display("FAIL hold_idle got %h exp 407", {m_ov, m_gt, m_eq, m_lt, m_cnt});
        end
        apply(2'b00, 2'b11, 1'b0, 1'b0);
        checks++;
        if ({m_ov, m_gt, m_eq, m_lt, m_cnt} !== {4'b0100, 8'd7}) begin
            errors++; $display("FAIL hold_idle2 got %h exp 407", {m_ov, m_gt, m_eq, m_lt, m_cnt});
        end
    endtask

    task automatic test_clear;
        apply(2'b11, 2'b00, 1'b1, 1'b1);
        checks++;
        if ({m_ov, m_gt, m_eq, m_lt, m_cnt} !== {4'b1100, 8'd0}) begin
            errors++; $display("FAIL clear_prio got %h exp c00", {m_ov, m_gt, m_eq, m_lt, m_cnt});
        end
        checks++;
        if (s_cnt !== 2'd0) begin
            errors++; $display("FAIL clear_sat got %0d exp 0", s_cnt);
        end
    endtask

    task automatic test_saturation;
        logic [1:0] exp_c [5];
        exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int k = 0; k < 5; k++) begin
            apply(2'b11, 2'b00, 1'b1, 1'b0);
            checks++;
            if (s_cnt !== exp_c[k]) begin
                errors++; $display("FAIL sat_step%0d got %0d exp %0d", k, s_cnt, exp_c[k]);
            end
        end
        checks++;
        if (m_cnt !== 8'd5) begin
            errors++; $display("FAIL sat_wide got %0d exp 5", m_cnt);
        end
    endtask

    task automatic test_signed;
        apply(2'b11, 2'b10, 1'b1, 1'b0);
        checks++;
        if ({g_ov, g_gt, g_eq, g_lt} !== 4'b1100) begin
            errors++; $display("FAIL sgn_m1_m2 got %b exp 1100", {g_ov, g_gt, g_eq, g_lt});
        end
        apply(2'b01, 2'b11, 1'b1, 1'b0);
        checks++;
        if ({g_ov, g_gt, g_eq, g_lt} !== 4'b1100) begin
            errors++; $display("FAIL sgn_p1_m1 got %b exp 1100", {g_ov, g_gt, g_eq, g_lt});
        end
        checks++;
        if ({m_ov, m_gt, m_eq, m_lt} !== 4'b1001) begin
            errors++; $display("FAIL uns_1_3 got %b exp 1001", {m_ov, m_gt, m_eq, m_lt});
        end
        apply(2'b10, 2'b01, 1'b1, 1'b0);
        checks++;
        if ({g_ov, g_gt, g_eq, g_lt} !== 4'b1001) begin
            errors++; $display("FAIL sgn_m2_p1 got %b exp 1001", {g_ov, g_gt, g_eq, g_lt});
        end
        apply(2'b11, 2'b11, 1'b1, 1'b0);
        checks++;
        if ({g_ov, g_gt, g_eq, g_lt} !== 4'b1010) begin
            errors++; $display("FAIL sgn_eq got %b exp 1010", {g_ov, g_gt, g_eq, g_lt});
        end
        checks++;
        if (g_cnt !== 8'd2) begin
            errors++; $display("FAIL sgn_count got %0d exp 2", g_cnt);
        end
    endtask

    task automatic test_mid_reset;
        apply(2'b11, 2'b00, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({m_ov, m_gt, m_eq, m_lt, m_cnt} !== 12'h000) begin
            errors++; $display("FAIL midrst_main got %h exp 000", {m_ov, m_gt, m_eq, m_lt, m_cnt});
        end
        checks++;
        if ({s_ov, s_gt, s_cnt, g_ov, g_gt, g_eq, g_cnt} !== 15'h0) begin
            errors++; $display("FAIL midrst_others got %h exp 0",
                               {s_ov, s_gt, s_cnt, g_ov, g_gt, g_eq, g_cnt});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({m_ov, m_gt, m_eq, m_lt, m_cnt} !== {4'b1100, 8'd1}) begin
            errors++; $display("FAIL midrst_first got %h exp c01", {m_ov, m_gt, m_eq, m_lt, m_cnt});
        end
    endtask

    initial begin
        test_reset;
        test_sweep;
        test_hold;
        test_clear;
        test_saturation;
        test_signed;
        test_mid_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
